// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous-read unified memory between two requesters.
// Port 0 (CPU core) has priority; a hold counter bounds how many
// consecutive port-0 grants port 1 can be made to wait through.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   m0_req/we/addr/wdata         port 0 request inputs
//   m0_gnt                       port 0 access performed this cycle
//   m0_rvalid/m0_rdata           port 0 read return (one cycle after gnt)
//   m1_*                         identical set for port 1
//   mem_we/mem_addr/mem_wdata    memory command, driven for the granted port
//   mem_rdata                    memory read data (valid cycle after address)
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  logic [3:0] hold_cnt_r;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       any_gnt_s;
  logic       mem_we_s;
  // Read tag kept one-hot: at most one of these is set, marking the owner
  // of the read issued in the previous cycle.
  logic       rvalid0_r;
  logic       rvalid1_r;

  // Grant decision: port 0 wins unless port 1 has waited out the hold budget.
  // Reset low forces both grants off irrespective of the request inputs.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!reset_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (m0_req && m1_req) begin
      if (hold_cnt_r >= MAX_HOLD_C) begin
        gnt1_s = 1'b1;
      end else begin
        gnt0_s = 1'b1;
      end
    end else if (m0_req) begin
      gnt0_s = 1'b1;
    end else if (m1_req) begin
      gnt1_s = 1'b1;
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign any_gnt_s = gnt0_s | gnt1_s;
  assign mem_we_s  = (gnt0_s & m0_we) | (gnt1_s & m1_we);

  // Memory command mux: port 1 only when it owns the cycle, else port 0.
  always_comb begin
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    if (gnt1_s) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end
  end

  assign mem_we = mem_we_s;
  assign m0_gnt = gnt0_s;
  assign m1_gnt = gnt1_s;

  // Hold counter: counts port-0 grants taken while port 1 is waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_r <= 4'd0;
    end else if (gnt1_s || !m1_req) begin
      hold_cnt_r <= 4'd0;
    end else if (gnt0_s && (hold_cnt_r < MAX_HOLD_C)) begin
      hold_cnt_r <= hold_cnt_r + 4'd1;
    end else begin
      hold_cnt_r <= hold_cnt_r;
    end
  end

  // Read tag: remember which port issued a read so the next cycle's
  // memory data is attributed to it. Writes leave the tag clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      rvalid0_r <= any_gnt_s & ~mem_we_s & gnt0_s;
      rvalid1_r <= any_gnt_s & ~mem_we_s & gnt1_s;
    end
  end

  assign m0_rvalid = rvalid0_r;
  assign m1_rvalid = rvalid1_r;
  // Read data is broadcast; rvalid alone says whose it is.
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a vector
// table for the arbitration order, and a random phase checked against a
// behavioural model (request age + read FIFO + shadow memory).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 4;

  logic          clk;
  logic          reset_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench memory: 64 words, synchronous read, plus a preload port.
  logic [DW-1:0] mem [0:63];
  logic          pl_en;
  logic [5:0]    pl_idx;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[7:2]];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pl_idx  = 6'(idx);
    pl_data = d;
    pl_en   = 1'b1;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  typedef struct packed {
    logic r0, w0, r1, w1;
    logic g0, g1, we;
  } vec_t;

  vec_t vecs [0:19];
  logic own5 [0:7];
  logic [31:0] ref_mem [0:63];

  initial begin
    pl_en = 1'b0; pl_idx = 6'd0; pl_data = 32'd0;
    reset_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;

    // Vector table: both-request starvation bound, the simultaneous
    // drop at MAX_HOLD, and single-requester cases.
    for (int i = 0; i < 10; i++)
      vecs[i] = {1'b1, 1'b0, 1'b1, 1'b0, !(i == 4 || i == 9), (i == 4 || i == 9), 1'b0};
    for (int i = 10; i < 14; i++)
      vecs[i] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[17] = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[18] = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[19] = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    own5 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    // Fill memory with a known pattern while in reset.
    tick();
    for (int i = 0; i < 64; i++) preload(i, 32'h5A00_0000 + 32'(i * 17));

    // 1. Reset with both ports requesting writes.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hFC;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hF8;
    @(negedge clk);
    chk1("rst_m0_gnt", m0_gnt, 1'b0);
    chk1("rst_m1_gnt", m1_gnt, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk1("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk1("rst_m1_rvalid", m1_rvalid, 1'b0);
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_m0_gnt", m0_gnt, 1'b1);
    chk1("post_rst_m1_gnt", m1_gnt, 1'b0);
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    tick();

    // 2. m0 read of 0x10.
    preload(4, 32'hDEADBEEF);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    @(negedge clk);
    chk1("t2_m0_gnt", m0_gnt, 1'b1);
    chk32("t2_mem_addr", mem_addr, 32'h10);
    chk1("t2_mem_we", mem_we, 1'b0);
    tick();
    m0_req = 1'b0;

    // 3. m1 write 0x20 (overlapping m0's read return), then m1 read back.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    @(negedge clk);
    chk1("t2_m0_rvalid", m0_rvalid, 1'b1);
    chk32("t2_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk1("t2_m1_rvalid", m1_rvalid, 1'b0);
    chk1("t3w_m1_gnt", m1_gnt, 1'b1);
    chk1("t3w_mem_we", mem_we, 1'b1);
    chk32("t3w_mem_addr", mem_addr, 32'h20);
    chk32("t3w_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    m1_we = 1'b0;
    @(negedge clk);
    chk1("t3w_m1_rvalid", m1_rvalid, 1'b0);
    chk1("t3w_m0_rvalid", m0_rvalid, 1'b0);
    chk1("t3r_m1_gnt", m1_gnt, 1'b1);
    chk1("t3r_mem_we", mem_we, 1'b0);
    tick();
    m1_req = 1'b0;
    @(negedge clk);
    chk1("t3r_m1_rvalid", m1_rvalid, 1'b1);
    chk32("t3r_m1_rdata", m1_rdata, 32'h12345678);
    chk1("t3r_m0_rvalid", m0_rvalid, 1'b0);
    tick();

    // 4. Vector table from a fresh reset.
    reset_pulse();
    m0_addr = 32'hC0; m1_addr = 32'hC4;
    m0_wdata = 32'hA5A5_0001; m1_wdata = 32'hA5A5_0002;
    for (int i = 0; i < 20; i++) begin
      {m0_req, m0_we, m1_req, m1_we} = {vecs[i].r0, vecs[i].w0, vecs[i].r1, vecs[i].w1};
      @(negedge clk);
      chk1($sformatf("vec%0d_m0_gnt", i), m0_gnt, vecs[i].g0);
      chk1($sformatf("vec%0d_m1_gnt", i), m1_gnt, vecs[i].g1);
      chk1($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].we);
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;

    // 5. Interleaved continuous reads.
    preload(0, 32'hA0A0A0A0);
    preload(1, 32'hB1B1B1B1);
    reset_pulse();
    m0_addr = 32'h0; m1_addr = 32'h4;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i == 8) begin m0_req = 1'b0; m1_req = 1'b0; end
      @(negedge clk);
      if (i < 8) begin
        chk1($sformatf("t5_c%0d_m0_gnt", i), m0_gnt, !own5[i]);
        chk1($sformatf("t5_c%0d_m1_gnt", i), m1_gnt, own5[i]);
      end
      if (i > 0) begin
        chk1($sformatf("t5_c%0d_m0_rvalid", i), m0_rvalid, !own5[i-1]);
        chk1($sformatf("t5_c%0d_m1_rvalid", i), m1_rvalid, own5[i-1]);
        chk32($sformatf("t5_c%0d_rdata", i), own5[i-1] ? m1_rdata : m0_rdata,
              own5[i-1] ? 32'hB1B1B1B1 : 32'hA0A0A0A0);
      end
      tick();
    end

    // 6. Reset during the return cycle of an m0 read, with hold built up.
    reset_pulse();
    m0_addr = 32'h10; m1_addr = 32'h4;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1($sformatf("t6_pre%0d_m0_gnt", i), m0_gnt, 1'b1);
      tick();
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk1("t6_rst_m0_rvalid", m0_rvalid, 1'b0);
    chk1("t6_rst_m1_rvalid", m1_rvalid, 1'b0);
    chk1("t6_rst_m0_gnt", m0_gnt, 1'b0);
    chk1("t6_rst_m1_gnt", m1_gnt, 1'b0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1($sformatf("t6_post%0d_m1_gnt", i), m1_gnt, (i == 4));
      chk1($sformatf("t6_post%0d_m0_gnt", i), m0_gnt, (i != 4));
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick();

    // 7. Random traffic against a behavioural model.
    begin
      int          m1_wait;
      logic        pend_v, pend_own, eg0, eg1, ewe, last_g0, last_g1;
      logic [31:0] pend_data;
      logic [5:0]  idx;
      reset_pulse();
      for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
      m1_wait = 0; pend_v = 1'b0; pend_own = 1'b0; pend_data = 32'h0;
      last_g0 = 1'b0; last_g1 = 1'b0;
      for (int c = 0; c < 1500; c++) begin
        if (last_g0 || !m0_req) begin
          m0_req   = ($urandom_range(0, 9) < 6);
          m0_we    = $urandom_range(0, 1) == 1;
          m0_addr  = 32'($urandom_range(0, 15)) << 2;
          m0_wdata = $urandom;
        end
        if (last_g1 || !m1_req) begin
          m1_req   = ($urandom_range(0, 9) < 5);
          m1_we    = $urandom_range(0, 1) == 1;
          m1_addr  = 32'($urandom_range(0, 15)) << 2;
          m1_wdata = $urandom;
        end
        @(negedge clk);
        // Port 1 wins when alone or once it has waited MAX_HOLD cycles.
        eg1 = m1_req && (!m0_req || m1_wait >= MH);
        eg0 = m0_req && !eg1;
        ewe = (eg0 && m0_we) || (eg1 && m1_we);
        chk1("rnd_m0_gnt", m0_gnt, eg0);
        chk1("rnd_m1_gnt", m1_gnt, eg1);
        chk1("rnd_mem_we", mem_we, ewe);
        chk32("rnd_mem_addr", mem_addr, eg1 ? m1_addr : m0_addr);
        if (ewe) chk32("rnd_mem_wdata", mem_wdata, eg1 ? m1_wdata : m0_wdata);
        chk1("rnd_m0_rvalid", m0_rvalid, pend_v && !pend_own);
        chk1("rnd_m1_rvalid", m1_rvalid, pend_v && pend_own);
        if (pend_v) chk32("rnd_rdata", pend_own ? m1_rdata : m0_rdata, pend_data);
        pend_v = 1'b0;
        if (eg0 || eg1) begin
          idx = eg1 ? m1_addr[7:2] : m0_addr[7:2];
          if (ewe) begin
            ref_mem[idx] = eg1 ? m1_wdata : m0_wdata;
          end else begin
            pend_v    = 1'b1;
            pend_own  = eg1;
            pend_data = ref_mem[idx];
          end
        end
        m1_wait = (m1_req && !eg1) ? m1_wait + 1 : 0;
        last_g0 = eg0;
        last_g1 = eg1;
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
